sc_aes_batch_ctrl: RTL and testbench
====================================

Name: sc_aes_batch_ctrl

Overview:
Acquisition sequencer between host_if and the sc_aes_444 cipher unit (64-bit key/text). On one host command it runs a programmable number of encryptions back-to-back, so the host needs one command per batch instead of one per trace.
- Plaintext source: chained (each ciphertext becomes the next plaintext) or fixed-vs-random (TVLA).
- Inter-run gap: programmable.
- Scope trigger: active during each core operation.

Parameters:
TIMEOUT, 255, max cycles allowed between core_start and core_busy rising; exceeding it aborts with err.
CNT_W, 16, width of run counter / cmd_count.
GAP_W, 8, width of cmd_gap.

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
cmd_start  in  1  1-cycle pulse, starts a batch (accepted in IDLE only)
cmd_abort  in  1  stop batch after current core operation
cmd_mode  in  1  0 = chained, 1 = fixed-vs-random
cmd_enc_dec  in  1  passed to core_enc_dec, latched at cmd_start
cmd_count  in  CNT_W  number of runs, latched at cmd_start
cmd_gap  in  GAP_W  idle cycles between runs, latched at cmd_start
cmd_seed  in  64  LFSR seed, latched at cmd_start (0 is replaced by 64'h1)
key_in  in  64  key, latched at cmd_start
text_in  in  64  initial/fixed plaintext, latched at cmd_start
core_start  out  1  1-cycle start pulse to cipher unit
core_enc_dec  out  1  mode to cipher unit
core_key  out  64  key to cipher unit
core_text  out  64  plaintext to cipher unit, stable from core_start until core_busy falls
core_busy  in  1  cipher unit busy
core_text_out  in  64  cipher result, valid when core_busy falls
busy  out  1  batch in progress
done  out  1  1-cycle pulse at batch end
err  out  1  timeout occurred in last batch; cleared at next accepted cmd_start
aborted  out  1  last batch ended by cmd_abort; cleared at next accepted cmd_start
result  out  64  last ciphertext captured
run_idx  out  CNT_W  number of completed runs
fvr_sel  out  1  class of current run (0 = fixed, 1 = random)
trig  out  1  high from core_start cycle through last cycle core_busy is high

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = 64'h1.

State machine (IDLE, START, WAIT_RISE, WAIT_FALL, GAP, DRAIN, FIN):
- IDLE:
  - cmd_start → latch all cmd_* and key/text inputs, clear err/aborted/run_idx, load LFSR, busy=1.
  - If cmd_count=0 → FIN; else → START.
  - cmd_abort in IDLE is ignored.
- START:
  - core_text selection:
    - chained: text_in for run 0, result afterwards.
    - FVR: LFSR steps once per run (Galois, taps 64,63,61,60); fvr_sel = new LFSR[0]; core_text = latched text_in if fvr_sel=0, else new LFSR state.
  - core_start=1 for exactly this cycle, trig=1 → WAIT_RISE.
- WAIT_RISE:
  - core_busy=1 → WAIT_FALL.
  - Timeout counter reaching TIMEOUT → err=1, FIN.
- WAIT_FALL:
  - core_busy sampled 0 → capture result=core_text_out, run_idx+1, trig=0.
  - If run_idx+1 = count, or an abort is pending → FIN; else → GAP.
- GAP: counts cmd_gap cycles → START. The next core_start is high exactly cmd_gap+1 cycles after the edge that sampled core_busy low.
- cmd_abort while busy:
  - Sets a pending flag, and aborted=1 at FIN.
  - In START/WAIT_RISE/WAIT_FALL: the current operation completes (DRAIN semantics: wait for core_busy low, capture result, count it) → FIN.
  - In GAP: → FIN next cycle, no further core_start.
- FIN: done=1 for one cycle, busy=0 → IDLE.
- cmd_start while busy is ignored.
- Ordering: done precedes any new accepted cmd_start by ≥1 cycle.
- run_idx saturates at cmd_count.
- Asynchronous reset mid-batch returns to IDLE immediately with no done pulse.
- core_key and core_enc_dec hold their latched values between batches.

Test Plan:
- Reset, then idle: all outputs 0, no core_start for 100 cycles.
- Chained, cmd_count=3, cmd_gap=4, behavioural core (busy 20 cycles, out = text XOR key):
  - Exactly 3 core_start pulses.
  - Each subsequent core_start 5 cycles after busy falls.
  - core_text of run 2 equals result of run 1.
  - Final result = text_in XOR key (odd number of XORs); run_idx=3; one done pulse.
- cmd_count=0 → done 2 cycles after cmd_start, no core_start, busy high for 1 cycle.
- FVR, cmd_count=8, cmd_seed=1:
  - Each run's core_text equals text_in when fvr_sel=0, otherwise the reference LFSR state.
  - fvr_sel sequence matches a software LFSR model.
- cmd_abort asserted mid WAIT_FALL of run 2 of 10 → run 2 completes, run_idx=2, aborted=1, done pulse, no third core_start.
- Core never asserting busy → err=1 and done exactly TIMEOUT+2 cycles after core_start; next cmd_start clears err.

Source files
------------

// File: rtl/sc_aes_batch_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | sc_aes_batch_ctrl_if                                                     |
// | Host command/status and cipher-core handshake bundle for the sequencer.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sc_aes_batch_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
);
  logic             cmd_start;
  logic             cmd_abort;
  logic             cmd_mode;
  logic             cmd_enc_dec;
  logic [CNT_W-1:0] cmd_count;
  logic [GAP_W-1:0] cmd_gap;
  logic [63:0]      cmd_seed;
  logic [63:0]      key_in;
  logic [63:0]      text_in;

  logic             core_start;
  logic             core_enc_dec;
  logic [63:0]      core_key;
  logic [63:0]      core_text;
  logic             core_busy;
  logic [63:0]      core_text_out;

  logic             busy;
  logic             done;
  logic             err;
  logic             aborted;
  logic [63:0]      result;
  logic [CNT_W-1:0] run_idx;
  logic             fvr_sel;
  logic             trig;

  modport slave (
    input  cmd_start, cmd_abort, cmd_mode, cmd_enc_dec, cmd_count, cmd_gap,
           cmd_seed, key_in, text_in, core_busy, core_text_out,
    output core_start, core_enc_dec, core_key, core_text,
           busy, done, err, aborted, result, run_idx, fvr_sel, trig
  );

  modport master (
    output cmd_start, cmd_abort, cmd_mode, cmd_enc_dec, cmd_count, cmd_gap,
           cmd_seed, key_in, text_in, core_busy, core_text_out,
    input  core_start, core_enc_dec, core_key, core_text,
           busy, done, err, aborted, result, run_idx, fvr_sel, trig
  );
endinterface

`default_nettype wire

// File: rtl/sc_aes_batch_ctrl.sv
// +--------------------------------------------------------------------------+
// | sc_aes_batch_ctrl                                                        |
// | Runs a batch of back-to-back cipher operations per host command.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sc_aes_batch_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16,
  parameter int GAP_W   = 8
) (
  input  logic              clock,
  input  logic              resetn,
  sc_aes_batch_ctrl_if.slave bus
);

  localparam int          TMO_W       = $clog2(TIMEOUT + 1);
  localparam logic [63:0] c_lfsr_mask = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_WAIT_FALL = 3'd3,
    S_GAP       = 3'd4,
    S_DRAIN     = 3'd5,
    S_FIN       = 3'd6
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_mode, r_enc_dec, r_fvr_sel;
  logic             r_err, r_aborted, r_done, r_abort_pend;
  logic [CNT_W-1:0] r_count, r_run_idx;
  logic [GAP_W-1:0] r_gap, r_gap_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic [63:0]      r_key, r_text, r_lfsr, r_core_text, r_result;

  logic             w_accept, w_capture, w_timeout, w_abort_any, w_last;
  logic             w_from_idle, w_mode, w_enter_start;
  logic [63:0]      w_seed, w_lfsr_cur, w_lfsr_nxt, w_base_text, w_chain_text, w_start_text;

  assign w_abort_any = r_abort_pend | bus.cmd_abort;
  assign w_last      = ((r_run_idx + CNT_W'(1)) == r_count);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_start) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.cmd_count == '0) ? S_FIN : S_START;
        end
      end
      S_START: w_state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (bus.core_busy) begin
          w_state_nxt = w_abort_any ? S_DRAIN : S_WAIT_FALL;
        end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_WAIT_FALL: begin
        if (!bus.core_busy) begin
          w_capture = 1'b1;
          if (w_last || w_abort_any) w_state_nxt = S_FIN;
          else if (r_gap == '0)      w_state_nxt = S_START;
          else                       w_state_nxt = S_GAP;
        end else if (w_abort_any) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.core_busy) begin
          w_capture   = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_GAP: begin
        if (w_abort_any)                           w_state_nxt = S_FIN;
        else if ((r_gap_cnt + GAP_W'(1)) == r_gap) w_state_nxt = S_START;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next run's plaintext is prepared on the edge entering START so core_text is valid with core_start.
  assign w_from_idle   = (r_state == S_IDLE);
  assign w_enter_start = (w_state_nxt == S_START);
  assign w_mode        = w_from_idle ? bus.cmd_mode : r_mode;
  assign w_seed        = (bus.cmd_seed == 64'h0) ? 64'h1 : bus.cmd_seed;
  assign w_lfsr_cur    = w_from_idle ? w_seed : r_lfsr;
  assign w_lfsr_nxt    = {1'b0, w_lfsr_cur[63:1]} ^ (w_lfsr_cur[0] ? c_lfsr_mask : 64'h0);
  assign w_base_text   = w_from_idle ? bus.text_in : r_text;
  assign w_chain_text  = w_from_idle ? bus.text_in : (w_capture ? bus.core_text_out : r_result);
  assign w_start_text  = w_mode ? (w_lfsr_nxt[0] ? w_lfsr_nxt : w_base_text) : w_chain_text;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mode       <= 1'b0;
      r_enc_dec    <= 1'b0;
      r_fvr_sel    <= 1'b0;
      r_err        <= 1'b0;
      r_aborted    <= 1'b0;
      r_done       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_count      <= '0;
      r_run_idx    <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
      r_tmo        <= '0;
      r_key        <= 64'h0;
      r_text       <= 64'h0;
      r_lfsr       <= 64'h1;
      r_core_text  <= 64'h0;
      r_result     <= 64'h0;
    end else begin
      r_done <= (r_state == S_FIN);

      if (w_accept) begin
        r_mode       <= bus.cmd_mode;
        r_enc_dec    <= bus.cmd_enc_dec;
        r_count      <= bus.cmd_count;
        r_gap        <= bus.cmd_gap;
        r_key        <= bus.key_in;
        r_text       <= bus.text_in;
        r_lfsr       <= w_seed;
        r_err        <= 1'b0;
        r_aborted    <= 1'b0;
        r_run_idx    <= '0;
        r_abort_pend <= 1'b0;
      end else if (bus.cmd_abort && (r_state != S_IDLE) && (r_state != S_FIN)) begin
        r_abort_pend <= 1'b1;
      end

      if (w_enter_start) begin
        r_core_text <= w_start_text;
        if (w_mode) begin
          r_lfsr    <= w_lfsr_nxt;
          r_fvr_sel <= w_lfsr_nxt[0];
        end else begin
          r_fvr_sel <= 1'b0;
        end
      end

      if (r_state == S_START)                        r_tmo <= '0;
      else if (r_state == S_WAIT_RISE && !w_timeout) r_tmo <= r_tmo + TMO_W'(1);

      if (r_state != S_GAP) r_gap_cnt <= '0;
      else                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);

      if (w_capture) begin
        r_result <= bus.core_text_out;
        if (r_run_idx != r_count) r_run_idx <= r_run_idx + CNT_W'(1);
      end

      if (w_timeout) r_err <= 1'b1;

      if (r_state == S_FIN) begin
        r_aborted    <= r_abort_pend;
        r_abort_pend <= 1'b0;
      end
    end
  end

  assign bus.core_start   = (r_state == S_START);
  assign bus.core_enc_dec = r_enc_dec;
  assign bus.core_key     = r_key;
  assign bus.core_text    = r_core_text;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.aborted      = r_aborted;
  assign bus.result       = r_result;
  assign bus.run_idx      = r_run_idx;
  assign bus.fvr_sel      = r_fvr_sel;
  // Trigger covers the start cycle and every cycle the core reports busy.
  assign bus.trig         = (r_state == S_START) || (r_state == S_WAIT_RISE) ||
                            (((r_state == S_WAIT_FALL) || (r_state == S_DRAIN)) && bus.core_busy);

endmodule

`default_nettype wire

// File: tb/tb_sc_aes_batch_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_sc_aes_batch_ctrl                                                     |
// | Randomized bench for the batch sequencer with a behavioural cipher core. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_sc_aes_batch_ctrl;
  localparam int CNT_W   = 16;
  localparam int GAP_W   = 8;
  localparam int TIMEOUT = 255;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  sc_aes_batch_ctrl_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();

  sc_aes_batch_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural cipher core: busy for core_lat cycles after core_start, out = text ^ key
  int core_lat  = 20;
  bit core_mute = 1'b0;
  int core_cnt;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.core_busy     <= 1'b0;
      bus.core_text_out <= 64'h0;
      core_cnt          <= 0;
    end else if (bus.core_start && !core_mute) begin
      bus.core_busy     <= 1'b1;
      bus.core_text_out <= bus.core_text ^ bus.core_key;
      core_cnt          <= core_lat - 1;
    end else if (bus.core_busy) begin
      if (core_cnt == 0) bus.core_busy <= 1'b0;
      else               core_cnt <= core_cnt - 1;
    end
  end

  // Monitor: append-only logs of starts, busy falls, done pulses
  int          cyc = 0;
  logic [63:0] st_text[$];
  bit          st_sel[$];
  int          st_cyc[$];
  int          fall_cyc[$];
  int          done_cnt = 0, done_cyc = 0, busy_cyc = 0;
  bit          prev_busy = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.core_start) begin
      st_text.push_back(bus.core_text);
      st_sel.push_back(bus.fvr_sel);
      st_cyc.push_back(cyc);
    end
    if (prev_busy && !bus.core_busy) fall_cyc.push_back(cyc);
    prev_busy <= bus.core_busy;
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.busy) busy_cyc <= busy_cyc + 1;
  end

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    // x^64 + x^63 + x^61 + x^60 + 1, right-shifting Galois form
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  task automatic drive_cmd(input bit mode, input int count, input int gap,
                           input logic [63:0] seed, input logic [63:0] key,
                           input logic [63:0] text, input bit enc, output int t_cmd);
    @(negedge clock);
    bus.cmd_mode    = mode;
    bus.cmd_count   = CNT_W'(count);
    bus.cmd_gap     = GAP_W'(gap);
    bus.cmd_seed    = seed;
    bus.key_in      = key;
    bus.text_in     = text;
    bus.cmd_enc_dec = enc;
    bus.cmd_start   = 1'b1;
    t_cmd           = cyc;
    @(negedge clock);
    bus.cmd_start   = 1'b0;
    bus.cmd_mode    = ~mode;
    bus.cmd_count   = CNT_W'($urandom);
    bus.cmd_gap     = GAP_W'($urandom);
    bus.cmd_seed    = ~seed;
    bus.key_in      = ~key;
    bus.text_in     = ~text;
    bus.cmd_enc_dec = ~enc;
  endtask

  // abort_mode: 0 none, 1 abort while run 2 busy, 2 abort in gap after run 1, 3 core never responds
  task automatic run_batch(input bit mode, input int count, input int gap,
                           input logic [63:0] seed, input logic [63:0] key,
                           input logic [63:0] text, input bit enc, input int lat,
                           input int abort_mode);
    int sb, fb, db, bb, t_cmd, exp_runs, k;
    logic [63:0] lf, exp_t, prev_res;
    bit exp_sel;
    sb = st_text.size(); fb = fall_cyc.size(); db = done_cnt; bb = busy_cyc;
    core_lat  = lat;
    core_mute = (abort_mode == 3);
    exp_runs  = count;
    drive_cmd(mode, count, gap, seed, key, text, enc, t_cmd);

    if (abort_mode == 1) begin
      for (k = 0; k < 5000; k++) begin
        if ((st_text.size() - sb) >= 2 && bus.core_busy) break;
        @(negedge clock);
      end
      chk("abort1_reach", 64'(k < 5000), 64'd1);
      repeat (3) @(negedge clock);
      chk("trig_during_busy", 64'(bus.trig), 64'd1);
      bus.cmd_abort = 1'b1;
      @(negedge clock);
      bus.cmd_abort = 1'b0;
      exp_runs = 2;
    end else if (abort_mode == 2) begin
      for (k = 0; k < 5000; k++) begin
        if ((fall_cyc.size() - fb) >= 1) break;
        @(negedge clock);
      end
      chk("abort2_reach", 64'(k < 5000), 64'd1);
      @(negedge clock);
      bus.cmd_abort = 1'b1;
      @(negedge clock);
      bus.cmd_abort = 1'b0;
      exp_runs = 1;
    end else if (abort_mode == 3) begin
      exp_runs = (count > 0) ? 1 : 0;
    end

    for (k = 0; k < 20000 && done_cnt == db; k++) @(negedge clock);
    chk("done_seen", 64'(done_cnt != db), 64'd1);
    repeat (40) @(negedge clock);

    chk("n_core_start", 64'(st_text.size() - sb), 64'(exp_runs));
    chk("done_pulses", 64'(done_cnt - db), 64'd1);
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("trig_after", 64'(bus.trig), 64'd0);
    chk("err", 64'(bus.err), 64'(abort_mode == 3));
    chk("aborted", 64'(bus.aborted), 64'(abort_mode == 1 || abort_mode == 2));
    chk("core_key", bus.core_key, key);
    chk("enc_dec", 64'(bus.core_enc_dec), 64'(enc));

    lf = (seed == 64'h0) ? 64'h1 : seed;
    prev_res = 64'h0;
    for (int i = 0; i < exp_runs && (sb + i) < st_text.size(); i++) begin
      if (mode) begin
        lf      = lfsr_next(lf);
        exp_sel = lf[0];
        exp_t   = exp_sel ? lf : text;
      end else begin
        exp_sel = 1'b0;
        exp_t   = (i == 0) ? text : prev_res;
      end
      chk($sformatf("core_text[%0d]", i), st_text[sb + i], exp_t);
      chk($sformatf("fvr_sel[%0d]", i), 64'(st_sel[sb + i]), 64'(exp_sel));
      if (i == 0) chk("first_start_lat", 64'(st_cyc[sb] - t_cmd), 64'd1);
      else if ((fb + i - 1) < fall_cyc.size())
        chk($sformatf("gap_lat[%0d]", i), 64'(st_cyc[sb + i] - fall_cyc[fb + i - 1]), 64'(gap + 1));
      prev_res = exp_t ^ key;
    end

    if (abort_mode == 3) begin
      chk("run_idx_tmo", 64'(bus.run_idx), 64'd0);
      if (exp_runs > 0 && st_text.size() > sb)
        chk("timeout_done_lat", 64'(done_cyc - st_cyc[sb]), 64'(TIMEOUT + 2));
    end else begin
      chk("run_idx", 64'(bus.run_idx), 64'(exp_runs));
      if (exp_runs > 0) chk("result", bus.result, prev_res);
    end
    if (count == 0) begin
      chk("zero_done_lat", 64'(done_cyc - t_cmd), 64'd2);
      chk("zero_busy_cycles", 64'(busy_cyc - bb), 64'd1);
    end
    core_mute = 1'b0;
  endtask

  initial begin
    logic [63:0] acc;
    int t_cmd, db;
    bus.cmd_start = 1'b0; bus.cmd_abort = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_enc_dec = 1'b0;
    bus.cmd_count = '0; bus.cmd_gap = '0; bus.cmd_seed = 64'h0;
    bus.key_in = 64'h0; bus.text_in = 64'h0;

    repeat (3) @(negedge clock);
    resetn = 1'b1;

    acc = 64'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      acc |= bus.core_key | bus.core_text | bus.result | 64'(bus.run_idx) |
             64'({bus.core_start, bus.core_enc_dec, bus.busy, bus.done,
                  bus.err, bus.aborted, bus.fvr_sel, bus.trig});
    end
    chk("reset_idle_outputs", acc, 64'h0);
    chk("reset_no_core_start", 64'(st_text.size()), 64'd0);

    run_batch(1'b0, 3, 4, 64'h5, 64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 20, 0);
    run_batch(1'b0, 0, 2, 64'h5, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 20, 0);
    run_batch(1'b1, 8, 2, 64'h1, 64'hA5A5_0F0F_F0F0_5A5A, 64'h0BAD_F00D_1234_5678, 1'b1, 5, 0);
    run_batch(1'b1, 10, 3, 64'h0, 64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0, 1'b0, 20, 1);
    run_batch(1'b0, 10, 6, 64'h7, 64'hFEDC_BA98_7654_3210, 64'h0011_2233_4455_6677, 1'b1, 4, 2);
    run_batch(1'b0, 3, 1, 64'h9, 64'hCAFE_BABE_0000_FFFF, 64'h1234_0000_5678_0000, 1'b0, 8, 3);
    run_batch(1'b0, 0, 0, 64'h9, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b0, 8, 0);

    for (int n = 0; n < 8; n++) begin
      run_batch(1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(0, 5),
                (n == 0) ? 64'h0 : {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(1, 8), 0);
    end

    // Asynchronous reset in the middle of a batch
    core_lat = 20;
    db = done_cnt;
    drive_cmd(1'b0, 5, 2, 64'h3, 64'h1, 64'h2, 1'b1, t_cmd);
    repeat (10) @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_trig", 64'(bus.trig), 64'd0);
    chk("async_rst_key", bus.core_key, 64'h0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (30) @(negedge clock);
    chk("async_rst_no_done", 64'(done_cnt - db), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
